// File: rtl/fb_port_arbiter.sv
// Frame-buffer arbiter for the 64x64 panel: display reads own the RAM port whenever
// they ask; pixel read-modify-writes and full-screen clears use the remaining cycles.
module fb_port_arbiter #(
  parameter bit CLR_ON_RESET = 1'b0,
  parameter int DISP_ADDR_W  = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   disp_req,
  input  logic [DISP_ADDR_W-1:0] disp_addr,
  output logic [23:0]            disp_rdata,
  output logic                   disp_valid,
  input  logic                   pix_req,
  input  logic [5:0]             pix_x,
  input  logic [5:0]             pix_y,
  input  logic [11:0]            pix_color,
  output logic                   pix_ack,
  output logic                   pix_busy,
  input  logic                   clr_req,
  input  logic [11:0]            clr_color,
  output logic                   clr_busy,
  output logic                   clr_done,
  output logic [DISP_ADDR_W-1:0] mem_addr,
  output logic                   mem_we,
  output logic [23:0]            mem_wdata,
  input  logic [23:0]            mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_P_RD  = 3'd1,
    S_P_CAP = 3'd2,
    S_P_WR  = 3'd3,
    S_CLR   = 3'd4
  } state_t;

  localparam logic [DISP_ADDR_W-1:0] ADDR_ONE  = {{(DISP_ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DISP_ADDR_W-1:0] ADDR_LAST = {DISP_ADDR_W{1'b1}};

  // Plane i of a word is {upper RGB, lower RGB}; overwrite one slice with colour bit i.
  function automatic logic [23:0] merge_pixel(input logic [23:0] word,
                                              input logic        lower,
                                              input logic [11:0] color);
    logic [23:0] res;
    res = word;
    for (int i = 0; i < 4; i++) begin
      if (lower) begin
        res[6*i +: 3] = {color[8+i], color[4+i], color[i]};
      end else begin
        res[6*i+3 +: 3] = {color[8+i], color[4+i], color[i]};
      end
    end
    return res;
  endfunction

  function automatic logic [23:0] fill_word(input logic [11:0] color);
    logic [23:0] res;
    res = 24'd0;
    for (int i = 0; i < 4; i++) begin
      res[6*i +: 6] = {2{color[8+i], color[4+i], color[i]}};
    end
    return res;
  endfunction

  state_t                   state_q, state_d;
  logic [5:0]               x_q, x_d;
  logic [5:0]               y_q, y_d;
  logic [11:0]              color_q, color_d;
  logic [11:0]              clr_color_q, clr_color_d;
  logic [DISP_ADDR_W-1:0]   cnt_q, cnt_d;
  logic [23:0]              wdata_q, wdata_d;
  logic                     disp_valid_q, disp_valid_d;

  logic [DISP_ADDR_W-1:0]   fsm_addr_s;
  logic                     fsm_we_s;
  logic [23:0]              fsm_wdata_s;
  logic                     ack_s;
  logic                     done_s;
  logic                     port_free_s;

  assign port_free_s = ~disp_req;

  // Next-state and port request of the pixel/clear engine.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    color_d      = color_q;
    clr_color_d  = clr_color_q;
    cnt_d        = cnt_q;
    wdata_d      = wdata_q;
    disp_valid_d = disp_req;
    fsm_addr_s   = {y_q[4:0], x_q};
    fsm_we_s     = 1'b0;
    fsm_wdata_s  = wdata_q;
    ack_s        = 1'b0;
    done_s       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          clr_color_d = clr_color;
          cnt_d       = {DISP_ADDR_W{1'b0}};
          state_d     = S_CLR;
        end else if (pix_req) begin
          x_d     = pix_x;
          y_d     = pix_y;
          color_d = pix_color;
          state_d = S_P_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_P_RD: begin
        if (port_free_s) begin
          state_d = S_P_CAP;
        end else begin
          state_d = S_P_RD;
        end
      end
      S_P_CAP: begin
        // The paint read was issued last cycle and nothing can have displaced it.
        wdata_d = merge_pixel(mem_rdata, y_q[5], color_q);
        state_d = S_P_WR;
      end
      S_P_WR: begin
        if (port_free_s) begin
          fsm_we_s = 1'b1;
          ack_s    = 1'b1;
          state_d  = S_IDLE;
        end else begin
          state_d = S_P_WR;
        end
      end
      S_CLR: begin
        fsm_addr_s  = cnt_q;
        fsm_wdata_s = fill_word(clr_color_q);
        if (port_free_s) begin
          fsm_we_s = 1'b1;
          cnt_d    = cnt_q + ADDR_ONE;
          if (cnt_q == ADDR_LAST) begin
            done_s  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_CLR;
          end
        end else begin
          state_d = S_CLR;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and latched-request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLR_ON_RESET ? S_CLR : S_IDLE;
      x_q          <= 6'd0;
      y_q          <= 6'd0;
      color_q      <= 12'd0;
      clr_color_q  <= 12'd0;
      cnt_q        <= {DISP_ADDR_W{1'b0}};
      wdata_q      <= 24'd0;
      disp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      color_q      <= color_d;
      clr_color_q  <= clr_color_d;
      cnt_q        <= cnt_d;
      wdata_q      <= wdata_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  // Port mux: display wins outright; everything is held low while rst is asserted.
  always_comb begin
    mem_addr  = {DISP_ADDR_W{1'b0}};
    mem_we    = 1'b0;
    mem_wdata = 24'd0;
    pix_ack   = 1'b0;
    clr_done  = 1'b0;
    pix_busy  = 1'b0;
    clr_busy  = 1'b0;
    if (rst) begin
      mem_addr = {DISP_ADDR_W{1'b0}};
    end else if (disp_req) begin
      mem_addr = disp_addr;
      pix_busy = (state_q != S_IDLE) && (state_q != S_CLR);
      clr_busy = (state_q == S_CLR);
    end else begin
      mem_addr  = fsm_addr_s;
      mem_we    = fsm_we_s;
      mem_wdata = fsm_we_s ? fsm_wdata_s : 24'd0;
      pix_ack   = ack_s;
      clr_done  = done_s;
      pix_busy  = (state_q != S_IDLE) && (state_q != S_CLR);
      clr_busy  = (state_q == S_CLR);
    end
  end

  assign disp_rdata = mem_rdata;
  assign disp_valid = disp_valid_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: RAM models for a default instance and a clear-on-reset
// instance; expected RAM writes are queued at stimulus time and popped on each write.
module tb_fb_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ack_cnt = 0;

  logic        rst = 1'b1;
  logic        disp_req = 1'b0;
  logic [10:0] disp_addr = 11'd0;
  logic [23:0] disp_rdata;
  logic        disp_valid;
  logic        pix_req = 1'b0;
  logic [5:0]  pix_x = 6'd0;
  logic [5:0]  pix_y = 6'd0;
  logic [11:0] pix_color = 12'd0;
  logic        pix_ack, pix_busy;
  logic        clr_req = 1'b0;
  logic [11:0] clr_color = 12'd0;
  logic        clr_busy, clr_done;
  logic [10:0] mem_addr;
  logic        mem_we;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata;

  logic        rst_b = 1'b1;
  logic        zero1_b = 1'b0;
  logic [10:0] zero11_b = 11'd0;
  logic [5:0]  zero6_b = 6'd0;
  logic [11:0] zero12_b = 12'd0;
  logic [23:0] disp_rdata_b;
  logic        disp_valid_b, pix_ack_b, pix_busy_b, clr_busy_b, clr_done_b;
  logic [10:0] mem_addr_b;
  logic        mem_we_b;
  logic [23:0] mem_wdata_b;
  logic [23:0] mem_rdata_b;

  logic        pre_we = 1'b0;
  logic [10:0] pre_addr = 11'd0;
  logic [23:0] pre_data = 24'd0;
  logic [23:0] mem_a [0:2047];
  logic [23:0] mem_b [0:2047];

  typedef struct packed {
    logic [10:0] addr;
    logic [23:0] data;
  } wr_t;
  wr_t exp_q[$];
  wr_t exp_e;

  fb_port_arbiter #(.CLR_ON_RESET(1'b0)) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_rdata(disp_rdata), .disp_valid(disp_valid),
    .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .pix_ack(pix_ack), .pix_busy(pix_busy),
    .clr_req(clr_req), .clr_color(clr_color), .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  fb_port_arbiter #(.CLR_ON_RESET(1'b1)) dut_cor (
    .clk(clk), .rst(rst_b),
    .disp_req(zero1_b), .disp_addr(zero11_b), .disp_rdata(disp_rdata_b), .disp_valid(disp_valid_b),
    .pix_req(zero1_b), .pix_x(zero6_b), .pix_y(zero6_b), .pix_color(zero12_b),
    .pix_ack(pix_ack_b), .pix_busy(pix_busy_b),
    .clr_req(zero1_b), .clr_color(zero12_b), .clr_busy(clr_busy_b), .clr_done(clr_done_b),
    .mem_addr(mem_addr_b), .mem_we(mem_we_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  always @(posedge clk) begin
    if (pre_we) mem_a[pre_addr] <= pre_data;
    else if (mem_we) mem_a[mem_addr] <= mem_wdata;
    mem_rdata <= mem_a[mem_addr];
  end

  always @(posedge clk) begin
    if (mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
    mem_rdata_b <= mem_b[mem_addr_b];
  end

  // Scoreboard: every RAM write of the main instance must match the next queued entry.
  always @(negedge clk) begin
    if (pix_ack) ack_cnt++;
    if (!rst && mem_we) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", mem_addr, mem_wdata);
      end else begin
        exp_e = exp_q.pop_front();
        if (mem_addr !== exp_e.addr || mem_wdata !== exp_e.data) begin
          bad++;
          $display("FAIL ram_write: got addr=%h data=%h, required addr=%h data=%h",
                   mem_addr, mem_wdata, exp_e.addr, exp_e.data);
        end
      end
    end
  end

  // Independent pixel model: bit positions per plane from the word layout.
  function automatic logic [23:0] paint_model(input logic [23:0] old, input logic [5:0] y,
                                              input logic [11:0] c);
    logic [23:0] w;
    int lsb;
    w = old;
    for (int p = 0; p < 4; p++) begin
      lsb = y[5] ? 6*p : 6*p + 3;
      w[lsb]     = c[p];
      w[lsb + 1] = c[4 + p];
      w[lsb + 2] = c[8 + p];
    end
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [10:0] a, input logic [23:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    step();
    pre_we   = 1'b0;
  endtask

  task automatic test_reset();
    disp_req  = 1'b1;
    disp_addr = 11'h005;
    preload(11'h005, 24'h123456);
    step();
    @(negedge clk);
    total++;
    if ({mem_we, pix_ack, pix_busy, clr_busy, clr_done, disp_valid} !== 6'b0 ||
        mem_addr !== 11'd0 || mem_wdata !== 24'd0) begin
      bad++;
      $display("FAIL reset_outputs: got we=%b ack=%b pb=%b cb=%b cd=%b dv=%b addr=%h wd=%h, required all 0",
               mem_we, pix_ack, pix_busy, clr_busy, clr_done, disp_valid, mem_addr, mem_wdata);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (mem_addr !== 11'h005 || mem_we !== 1'b0 || disp_valid !== 1'b0) begin
      bad++;
      $display("FAIL disp_port: got addr=%h we=%b dv=%b, required addr=005 we=0 dv=0", mem_addr, mem_we, disp_valid);
    end
    step();
    disp_req = 1'b0;
    @(negedge clk);
    total++;
    if (disp_valid !== 1'b1 || disp_rdata !== 24'h123456) begin
      bad++;
      $display("FAIL disp_read: got dv=%b data=%h, required dv=1 data=123456", disp_valid, disp_rdata);
    end
    step();
    @(negedge clk);
    total++;
    if (disp_valid !== 1'b0) begin
      bad++;
      $display("FAIL disp_valid_drop: got %b, required 0", disp_valid);
    end
  endtask

  task automatic test_paint(input logic [5:0] x, input logic [5:0] y, input logic [11:0] c,
                            input logic [23:0] old, input logic [23:0] expw);
    logic [10:0] a;
    int got;
    int a0;
    a = {y[4:0], x};
    preload(a, old);
    exp_q.push_back('{a, expw});
    a0 = ack_cnt;
    pix_x = x; pix_y = y; pix_color = c; pix_req = 1'b1;
    got = -1;
    for (int i = 1; i <= 12 && got < 0; i++) begin
      step();
      @(negedge clk);
      if (pix_ack) got = i;
    end
    step();
    pix_req = 1'b0;
    @(negedge clk);
    total++;
    if (got != 3 || pix_busy !== 1'b0) begin
      bad++;
      $display("FAIL paint_latency: got ack at T+%0d busy=%b, required T+3 busy=0", got, pix_busy);
    end
    total++;
    if (mem_a[a] !== expw || ack_cnt - a0 != 1) begin
      bad++;
      $display("FAIL paint_ram: got word=%h acks=%0d, required word=%h acks=1", mem_a[a], ack_cnt - a0, expw);
    end
  endtask

  task automatic test_disp_stall();
    logic [23:0] expw;
    logic prev;
    int got, vbad, pbad, a0;
    preload(11'h0C5, 24'h123456);
    expw = paint_model(24'h123456, 6'd3, 12'hF0A);
    exp_q.push_back('{11'h0C5, expw});
    a0 = ack_cnt;
    pix_x = 6'd5; pix_y = 6'd3; pix_color = 12'hF0A; pix_req = 1'b1;
    prev = 1'b0; got = -1; vbad = 0; pbad = 0;
    for (int i = 1; i <= 16 && got < 0; i++) begin
      step();
      disp_req  = (i <= 5);
      disp_addr = 11'h010;
      @(negedge clk);
      if (disp_valid !== prev) vbad++;
      if (disp_req && (mem_addr !== 11'h010 || mem_we !== 1'b0)) pbad++;
      prev = disp_req;
      if (pix_ack) got = i;
    end
    step();
    pix_req = 1'b0;
    disp_req = 1'b0;
    total++;
    if (got != 8) begin
      bad++;
      $display("FAIL stall_latency: got ack at T+%0d, required T+8", got);
    end
    total++;
    if (vbad != 0 || pbad != 0) begin
      bad++;
      $display("FAIL stall_display: got %0d valid errors %0d port errors, required 0 and 0", vbad, pbad);
    end
    total++;
    if (mem_a[11'h0C5] !== expw || ack_cnt - a0 != 1) begin
      bad++;
      $display("FAIL stall_ram: got word=%h acks=%0d, required word=%h acks=1", mem_a[11'h0C5], ack_cnt - a0, expw);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] e1, e2;
    int g1, g2;
    preload(11'h0C5, 24'h000000);
    e1 = paint_model(24'h000000, 6'd3, 12'h5A3);
    e2 = paint_model(e1, 6'd35, 12'hC3C);
    exp_q.push_back('{11'h0C5, e1});
    exp_q.push_back('{11'h0C5, e2});
    pix_x = 6'd5; pix_y = 6'd3; pix_color = 12'h5A3; pix_req = 1'b1;
    g1 = -1; g2 = -1;
    for (int i = 1; i <= 12 && g1 < 0; i++) begin
      step();
      @(negedge clk);
      if (pix_ack) g1 = i;
    end
    step();
    pix_y = 6'd35; pix_color = 12'hC3C;
    for (int i = 1; i <= 12 && g2 < 0; i++) begin
      step();
      @(negedge clk);
      if (pix_ack) g2 = i;
    end
    step();
    pix_req = 1'b0;
    total++;
    if (g1 != 3 || g2 != 3 || mem_a[11'h0C5] !== e2) begin
      bad++;
      $display("FAIL back_to_back: got acks T+%0d/T+%0d word=%h, required T+3/T+3 word=%h", g1, g2, mem_a[11'h0C5], e2);
    end
  endtask

  task automatic test_clear();
    int busy_err, done_err, acc, got;
    for (int a = 0; a < 2048; a++) exp_q.push_back('{a[10:0], 24'h249249});
    exp_q.push_back('{11'h201, paint_model(24'h249249, 6'd40, 12'h123)});
    clr_color = 12'h00F; clr_req = 1'b1;
    busy_err = 0; done_err = 0; acc = -1; got = -1;
    for (int i = 1; i <= 2070 && got < 0; i++) begin
      step();
      clr_req = 1'b0;
      if (i == 1000) begin
        pix_x = 6'd1; pix_y = 6'd40; pix_color = 12'h123; pix_req = 1'b1;
      end
      @(negedge clk);
      if (clr_busy !== (i <= 2048)) busy_err++;
      if (clr_done !== (i == 2048)) done_err++;
      if (pix_busy && acc < 0) acc = i;
      if (pix_ack) got = i;
    end
    step();
    pix_req = 1'b0;
    total++;
    if (busy_err != 0 || done_err != 0) begin
      bad++;
      $display("FAIL clear_flags: got %0d busy errors %0d done errors, required 0 and 0", busy_err, done_err);
    end
    total++;
    if (acc != 2050 || got != 2052) begin
      bad++;
      $display("FAIL clear_then_pixel: got busy at T+%0d ack at T+%0d, required T+2050 and T+2052", acc, got);
    end
  endtask

  task automatic test_reset_mid();
    int a0;
    preload(11'h247, 24'h777777);
    a0 = ack_cnt;
    pix_x = 6'd7; pix_y = 6'd9; pix_color = 12'hABC; pix_req = 1'b1;
    step();
    step();
    rst = 1'b1;
    pix_req = 1'b0;
    @(negedge clk);
    total++;
    if (mem_we !== 1'b0 || pix_ack !== 1'b0 || pix_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_cap: got we=%b ack=%b busy=%b, required 0 0 0", mem_we, pix_ack, pix_busy);
    end
    step();
    rst = 1'b0;
    repeat (4) step();
    @(negedge clk);
    total++;
    if (pix_busy !== 1'b0 || clr_busy !== 1'b0 || ack_cnt != a0 || mem_a[11'h247] !== 24'h777777) begin
      bad++;
      $display("FAIL reset_abandon: got pb=%b cb=%b acks=%0d word=%h, required 0 0 0 777777",
               pix_busy, clr_busy, ack_cnt - a0, mem_a[11'h247]);
    end
  endtask

  task automatic test_clr_on_reset();
    int wcnt, werr, done_at;
    logic first_we;
    @(negedge clk);
    total++;
    if (mem_we_b !== 1'b0 || clr_busy_b !== 1'b0 || clr_done_b !== 1'b0) begin
      bad++;
      $display("FAIL cor_reset: got we=%b cb=%b cd=%b, required 0 0 0", mem_we_b, clr_busy_b, clr_done_b);
    end
    step();
    rst_b = 1'b0;
    wcnt = 0; werr = 0; done_at = -1; first_we = 1'b0;
    for (int i = 1; i <= 2060; i++) begin
      @(negedge clk);
      if (i == 1) first_we = mem_we_b;
      if (mem_we_b) begin
        if (mem_addr_b !== wcnt[10:0] || mem_wdata_b !== 24'd0) werr++;
        wcnt++;
      end
      if (clr_done_b) done_at = i;
      step();
    end
    total++;
    if (first_we !== 1'b1 || wcnt != 2048 || werr != 0) begin
      bad++;
      $display("FAIL cor_writes: got first_we=%b writes=%0d errors=%0d, required 1 2048 0", first_we, wcnt, werr);
    end
    total++;
    if (done_at != 2048 || clr_busy_b !== 1'b0) begin
      bad++;
      $display("FAIL cor_done: got done at %0d busy=%b, required 2048 busy=0", done_at, clr_busy_b);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  rx, ry;
    logic [11:0] rc;
    logic [23:0] ro;
    test_reset();
    test_paint(6'd5, 6'd3, 12'hF0A, 24'hFFFFFF, 24'hBE7BE7);
    test_paint(6'd5, 6'd35, 12'hF0A, 24'hFFFFFF, 24'hF7CF7C);
    for (int k = 0; k < 4; k++) begin
      rx = 6'($urandom_range(0, 63));
      ry = 6'($urandom_range(0, 63));
      rc = 12'($urandom_range(0, 4095));
      ro = 24'($urandom);
      test_paint(rx, ry, rc, ro, paint_model(ro, ry, rc));
    end
    test_disp_stall();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    test_clr_on_reset();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_writes: got %0d pending, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
